mem_param: RTL

Parametrised successor to the 32x8 lab memory: a single-port synchronous RAM with configurable data width, depth and read latency. After reset it zero-fills the whole array with a hardware init sequencer, then services read/write commands. Reads return through a `rd_valid`-qualified pipeline, illegal commands are flagged, and optional per-word parity is available. It sits behind the same testbench-driven memory interface as the existing memory and is a drop-in replacement when `DATA_W=8`, `ADDR_W=5`, `RD_LAT=1`.

---
 rtl/mem_param.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_param.sv
// -----------------------------------------------------------------------------
// mem_param
//   Parametrised single-port synchronous RAM. After reset, a hardware sequencer
//   writes zero to every word. Once that finishes, the RAM services read and
//   write commands. Read data returns through a pipeline qualified by rd_valid.
//   With DATA_W=8, ADDR_W=5 and RD_LAT=1 it replaces the legacy 32x8 memory
//   without other changes.
//
// Parameters
//   DATA_W : data word width in bits (1..64)
//   ADDR_W : address width; depth is 2**ADDR_W words
//   RD_LAT : read latency in clock edges (1..4)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   read       in   read command
//   write      in   write command
//   addr       in   word address (every value is legal)
//   data_in    in   write data
//   data_out   out  read data; updates only with rd_valid, otherwise holds
//   rd_valid   out  one-cycle pulse per completed read
//   ready      out  high once the zero-fill sequence has finished
//   err        out  one-cycle pulse after read and write were both sampled high
//   parity_err out  parity mismatch on the returned word, qualified by rd_valid
//
// Build option
//   MEM_PARITY_EN : when defined, each word stores an extra even-parity bit
//                   and returned words are checked. When undefined, there is
//                   no parity storage and parity_err stays 0.
// -----------------------------------------------------------------------------
module mem_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              ready,
    output logic              err,
    output logic              parity_err
);

    localparam int DEPTH = 2**ADDR_W;
`ifdef MEM_PARITY_EN
    // The parity bit sits above the data bits in each stored word.
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] cnt_r;
    logic [WORD_W-1:0] mem_r [DEPTH];

    logic              wr_s;
    logic              rd_s;
    logic              both_s;
    logic [WORD_W-1:0] wr_word_s;
    logic [WORD_W-1:0] rd_word_s;
    logic              src_vld_s;
    logic [WORD_W-1:0] src_word_s;
    logic              par_bad_s;

`ifdef MEM_PARITY_EN
    // Even parity: this function returns 1 when the word holds an odd number
    // of ones. Storing that bit makes the data plus parity even.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    // Decode commands. These are accepted only in RUN and never on a reset edge.
    always_comb begin
        wr_s   = (state_r == RUN) && !rst && write && !read;
        rd_s   = (state_r == RUN) && !rst && read  && !write;
        both_s = (state_r == RUN) && !rst && read  && write;
    end

    // Build the stored word and select the word at the current address.
    always_comb begin
`ifdef MEM_PARITY_EN
        wr_word_s = {even_parity(data_in), data_in};
`else
        wr_word_s = data_in;
`endif
        rd_word_s = mem_r[addr];
    end

    // Storage array: zero-fill during INIT, then apply command writes in RUN.
    always_ff @(posedge clk) begin
        if (!rst && (state_r == INIT)) begin
            mem_r[cnt_r] <= {WORD_W{1'b0}};
        end else if (wr_s) begin
            mem_r[addr] <= wr_word_s;
        end
    end

    // Control FSM: init sequencer, ready flag and illegal-command flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= INIT;
            cnt_r   <= {ADDR_W{1'b0}};
            ready   <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= both_s;
            case (state_r)
                INIT: begin
                    cnt_r <= cnt_r + ADDR_W'(1);
                    // This edge clears the last word, so start serving commands.
                    if (&cnt_r) begin
                        state_r <= RUN;
                        ready   <= 1'b1;
                    end else begin
                        state_r <= INIT;
                        ready   <= 1'b0;
                    end
                end
                RUN: begin
                    state_r <= RUN;
                    ready   <= 1'b1;
                end
                default: begin
                    state_r <= INIT;
                    cnt_r   <= {ADDR_W{1'b0}};
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    // Read pipeline. The output register is the last stage. With RD_LAT=1
    // the word captured at the read edge goes straight into it. Longer
    // latencies add RD_LAT-1 stages in front of it.
    generate
        if (RD_LAT == 1) begin : g_direct
            // Feed the output stage straight from the array.
            always_comb begin
                src_vld_s  = rd_s;
                src_word_s = rd_word_s;
            end
        end else begin : g_pipe
            logic [RD_LAT-2:0] vld_r;
            logic [WORD_W-1:0] word_r [RD_LAT-1];

            // Shift read valids and words. Reset drops reads that are in flight.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_r <= {(RD_LAT-1){1'b0}};
                end else begin
                    vld_r[0] <= rd_s;
                    for (int i = 1; i < RD_LAT-1; i++) begin
                        vld_r[i] <= vld_r[i-1];
                    end
                end
                word_r[0] <= rd_word_s;
                for (int i = 1; i < RD_LAT-1; i++) begin
                    word_r[i] <= word_r[i-1];
                end
            end

            // Take the oldest stage as the source for the output register.
            always_comb begin
                src_vld_s  = vld_r[RD_LAT-2];
                src_word_s = word_r[RD_LAT-2];
            end
        end
    endgenerate

    // Recompute parity over the returned data and compare it with the stored bit.
    always_comb begin
`ifdef MEM_PARITY_EN
        par_bad_s = even_parity(src_word_s[DATA_W-1:0]) != src_word_s[DATA_W];
`else
        par_bad_s = 1'b0;
`endif
    end

    // Output register: data_out updates only with a completed read.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= {DATA_W{1'b0}};
            rd_valid   <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            rd_valid   <= src_vld_s;
            parity_err <= src_vld_s && par_bad_s;
            if (src_vld_s) begin
                data_out <= src_word_s[DATA_W-1:0];
            end else begin
                data_out <= data_out;
            end
        end
    end

endmodule
